memwb_skid_stage: RTL
=====================

# memwb_skid_stage

Parametrised MEM/WB pipeline stage for the 32-bit MIPS pipeline. It carries PC, instruction, ALU result, load data, destination register and writeback controls from MEM to WB. Adds over the plain stage register:
- valid/ready handshake with an optional two-entry skid buffer;
- synchronous flush;
- explicit load-data-valid hold, which replaces X-detection;
- a writeback forwarding port for the hazard unit;
- a saturating back-pressure counter.

## Interface
- DATA_W, 32: width of PC, instruction, ALU result, load data.
- RADDR_W, 5: register-address width.
- SKID, 1: 1 = two entries (registered in_ready); 0 = single entry (in_ready = ~out_valid | out_ready).
- CNT_W, 16: stall-counter width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low.
- in_valid  in  1  MEM beat present.
- in_ready  out  1  stage accepts beat.
- in_flush  in  1  drop all held and incoming beats.
- in_pc, in_instr, in_alu_res, in_mem_res  in  DATA_W each.
- in_mem_res_valid  in  1  in_mem_res is meaningful this beat.
- in_write_addr  in  RADDR_W.
- in_reg_write, in_mem_to_reg, in_pc_to_reg  in  1 each.
- out_valid  out  1; out_ready  in  1.
- out_pc, out_instr, out_alu_res, out_mem_res  out  DATA_W.
- out_write_addr  out  RADDR_W.
- out_reg_write  out  1  stored reg_write AND out_valid.
- out_mem_to_reg, out_pc_to_reg  out  1.
- fwd_valid  out  1; fwd_addr  out  RADDR_W; fwd_data  out  DATA_W.
- stall_cnt  out  CNT_W.

## Operation
- Accept when in_valid & in_ready & ~in_flush. Drain when out_valid & out_ready.
- Main entry drives all out_* fields. Skid entry exists only when SKID=1.
- Per edge, in priority order:
  - reset low: clear everything.
  - else in_flush: clear both valids.
  - else: if main is empty or draining, main loads from skid if skid is full, otherwise from the accepted input. If main is held and an input is accepted, the input goes to skid.
- Order is preserved. The skid entry is never overwritten while full.
- SKID=1: in_ready = ~skid_valid, registered.
- Load-data hold: last_mem register updates with in_mem_res on any accepted beat with in_mem_res_valid=1. The entry's stored mem_res = in_mem_res_valid ? in_mem_res : last_mem (pre-update value).
- Forwarding, combinational from the main entry:
  - fwd_valid = out_valid & reg_write & (write_addr != 0).
  - fwd_addr = out_write_addr.
  - fwd_data = pc_to_reg ? out_pc : mem_to_reg ? out_mem_res : out_alu_res.
- stall_cnt increments each cycle out_valid & ~out_ready holds, saturating at all-ones. Cleared only by reset.

## Timing
- Latency 1 cycle: a beat accepted at edge N is visible on out_* after edge N.
- Throughput 1 beat/cycle when out_ready=1.
- Reset (reset=0 at an edge) values:
  - all out_* = 0, out_valid = 0;
  - skid empty, in_ready = 1 (SKID=1), last_mem = 0, stall_cnt = 0.
- Flush: beat accepted in the flush cycle is discarded; out_valid = 0 next cycle. Data fields are not cleared. stall_cnt and last_mem keep their values.
- Reset mid-stall or with skid full: all beats are lost; reset wins over flush.
- SKID=1, both entries full and out_ready=1: main takes skid; skid empties; in_ready rises next cycle.
- Simultaneous drain and accept with skid empty: main is replaced; no bubble.
- out_valid=0: out_reg_write = 0 and fwd_valid = 0 regardless of stored controls.

## Structure
- Package memwb_pkg: a packed struct memwb_beat_t (pc, instr, alu_res, mem_res, write_addr, reg_write, mem_to_reg, pc_to_reg), DATA_W/RADDR_W defaults, and a function for the fwd_data select.
- One sub-module, memwb_entry: a single beat register with load enable and valid clear. Instantiated as main, plus skid under generate when SKID=1.
- Top level holds the control, last_mem, forwarding mux and counter.

## Test plan
- Reset: drive reset=0 for 2 cycles with in_valid=1 → out_valid=0, out_pc=0, stall_cnt=0, in_ready=1.
- Streaming: 4 beats PC=0x100..0x10C with out_ready=1 → same PCs appear one cycle later, back to back, no bubbles.
- Back-pressure: out_ready=0 after beat 0x100, offer 0x104 and 0x108 → 0x104 goes to skid; in_ready falls; 0x108 is held upstream; stall_cnt counts up. On release, order is 0x100, 0x104, 0x108.
- Load hold: beat A with mem_res=0xDEAD and valid=1, then beat B with mem_res=X and valid=0 → B's out_mem_res = 0xDEAD.
- Forwarding: write_addr=5, reg_write=1, mem_to_reg=1, mem_res=0x42 → fwd_valid=1, fwd_addr=5, fwd_data=0x42. Same with write_addr=0 → fwd_valid=0.
- Flush with skid full and in_valid=1 → next cycle out_valid=0 and in_ready=1; no stale beat ever appears.

Source files
------------

// File: rtl/memwb_pkg.sv
// rtl/memwb_pkg.sv - shared types and helpers for the MEM/WB skid stage
package memwb_pkg;

    localparam int MEMWB_DATA_W  = 32;
    localparam int MEMWB_RADDR_W = 5;

    // One MEM->WB beat as held by a stage entry.
    typedef struct packed {
        logic [MEMWB_DATA_W-1:0]  pc;
        logic [MEMWB_DATA_W-1:0]  instr;
        logic [MEMWB_DATA_W-1:0]  alu_res;
        logic [MEMWB_DATA_W-1:0]  mem_res;
        logic [MEMWB_RADDR_W-1:0] write_addr;
        logic                     reg_write;
        logic                     mem_to_reg;
        logic                     pc_to_reg;
    } memwb_beat_t;

    // Value the beat will write back: link PC beats load data beats ALU result.
    function automatic logic [MEMWB_DATA_W-1:0] fwd_select(input memwb_beat_t beat);
        if (beat.pc_to_reg) begin
            return beat.pc;
        end else if (beat.mem_to_reg) begin
            return beat.mem_res;
        end else begin
            return beat.alu_res;
        end
    endfunction

endpackage

// File: rtl/memwb_entry.sv
// rtl/memwb_entry.sv - single beat register with load enable and valid clear
module memwb_entry
    import memwb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  memwb_beat_t d,
    output memwb_beat_t q,
    output logic        valid
);

    // Load wins over clear so a drain-and-refill in one cycle leaves no bubble;
    // clear drops only the valid bit and keeps the payload.
    always_ff @(posedge clock) begin
        if (!reset) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/memwb_skid_stage.sv
// rtl/memwb_skid_stage.sv - MEM/WB pipeline stage with handshake, skid entry, flush and forwarding
module memwb_skid_stage
    import memwb_pkg::*;
#(
    parameter int DATA_W  = MEMWB_DATA_W,
    parameter int RADDR_W = MEMWB_RADDR_W,
    parameter int SKID    = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_flush,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [DATA_W-1:0]  in_instr,
    input  logic [DATA_W-1:0]  in_alu_res,
    input  logic [DATA_W-1:0]  in_mem_res,
    input  logic               in_mem_res_valid,
    input  logic [RADDR_W-1:0] in_write_addr,
    input  logic               in_reg_write,
    input  logic               in_mem_to_reg,
    input  logic               in_pc_to_reg,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_pc,
    output logic [DATA_W-1:0]  out_instr,
    output logic [DATA_W-1:0]  out_alu_res,
    output logic [DATA_W-1:0]  out_mem_res,
    output logic [RADDR_W-1:0] out_write_addr,
    output logic               out_reg_write,
    output logic               out_mem_to_reg,
    output logic               out_pc_to_reg,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0]  fwd_data,
    output logic [CNT_W-1:0]   stall_cnt
);

    memwb_beat_t        in_beat;
    memwb_beat_t        main_d;
    memwb_beat_t        main_q;
    memwb_beat_t        skid_q;
    logic               main_valid;
    logic               skid_valid;
    logic               main_free;
    logic               accept;
    logic               drain;
    logic               load_main;
    logic               clear_main;
    logic               load_skid;
    logic               clear_skid;
    logic [DATA_W-1:0]  last_mem;
    logic [CNT_W-1:0]   stall_q;

    assign main_free = ~main_valid | out_ready;
    assign accept    = in_valid & in_ready & ~in_flush;
    assign drain     = main_valid & out_ready;

    // Capture the incoming beat; a beat without fresh load data inherits the
    // last load data seen, so WB never sees an undefined mem_res.
    always_comb begin
        in_beat            = '0;
        in_beat.pc         = in_pc;
        in_beat.instr      = in_instr;
        in_beat.alu_res    = in_alu_res;
        in_beat.mem_res    = in_mem_res_valid ? in_mem_res : last_mem;
        in_beat.write_addr = in_write_addr;
        in_beat.reg_write  = in_reg_write;
        in_beat.mem_to_reg = in_mem_to_reg;
        in_beat.pc_to_reg  = in_pc_to_reg;
    end

    // Entry steering: a freed main entry refills from skid first to keep
    // order; an accepted beat only parks in skid while main is held.
    always_comb begin
        load_main  = ~in_flush & main_free & (skid_valid | accept);
        main_d     = skid_valid ? skid_q : in_beat;
        clear_main = in_flush | drain;
        load_skid  = accept & ~main_free;
        clear_skid = in_flush | (skid_valid & main_free);
    end

    memwb_entry u_main (
        .clock (clock),
        .reset (reset),
        .load  (load_main),
        .clear (clear_main),
        .d     (main_d),
        .q     (main_q),
        .valid (main_valid)
    );

    generate
        if (SKID != 0) begin : g_skid
            memwb_entry u_skid (
                .clock (clock),
                .reset (reset),
                .load  (load_skid),
                .clear (clear_skid),
                .d     (in_beat),
                .q     (skid_q),
                .valid (skid_valid)
            );
            // skid_valid is a flop, so in_ready is a registered signal and
            // cuts the combinational ready path back to MEM.
            assign in_ready = ~skid_valid;
        end else begin : g_no_skid
            assign skid_q     = '0;
            assign skid_valid = 1'b0;
            assign in_ready   = main_free;
        end
    endgenerate

    // Remember the most recent load data for beats that carry none; flush
    // and back-pressure leave it untouched.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_mem <= '0;
        end else if (accept && in_mem_res_valid) begin
            last_mem <= in_mem_res;
        end
    end

    // Count cycles where WB holds off a valid beat; sticks at all-ones.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (main_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign out_valid      = main_valid;
    assign out_pc         = main_q.pc;
    assign out_instr      = main_q.instr;
    assign out_alu_res    = main_q.alu_res;
    assign out_mem_res    = main_q.mem_res;
    assign out_write_addr = main_q.write_addr;
    assign out_reg_write  = main_q.reg_write & main_valid;
    assign out_mem_to_reg = main_q.mem_to_reg;
    assign out_pc_to_reg  = main_q.pc_to_reg;

    // Writes to r0 are architecturally discarded, so they never forward.
    assign fwd_valid = main_valid & main_q.reg_write & (main_q.write_addr != '0);
    assign fwd_addr  = main_q.write_addr;
    assign fwd_data  = fwd_select(main_q);

    assign stall_cnt = stall_q;

endmodule
